instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly downstream of the program counter. It owns the fetch address, issues word reads to instruction memory over a request/grant interface, and buffers returned instructions, each tagged with its PC, in a small FIFO. The FIFO drains to decode through a valid/ready handshake. A redirect (taken branch/jump target from execute) flushes the buffer, discards any in-flight read and restarts fetch at the new target.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues word reads to instruction memory, buffers PC-tagged words.
// Latency: grant in cycle n -> head valid to decode in n+2; sustains 1 instruction/cycle.
// Backpressure: requests stop while buffered + in-flight entries would exceed DEPTH; redirect flushes all.
module instr_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Gnt,
  input  logic        IMem_RValid,
  input  logic [31:0] IMem_RData,
  output logic        Instr_Valid,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  input  logic        Instr_Ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Architectural state
  logic          r_run;
  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];

  // Combinational control
  logic          w_pop;
  logic          w_push;
  logic          w_grant;
  logic [CW:0]   w_occ;
  logic [31:0]   w_redirect_pc;

  // A redirect overrides the pop: the whole buffer is being discarded anyway.
  assign Instr_Valid   = (r_count != '0);
  assign w_pop         = Instr_Valid & Instr_Ready & ~Redirect;
  // Occupancy after this cycle's pop, counting the outstanding read as a reserved slot.
  assign w_occ         = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign IMem_Req      = r_run & ~Redirect & (w_occ < (CW+1)'(DEPTH));
  assign IMem_Addr     = r_fetch_pc;
  assign w_grant       = IMem_Req & IMem_Gnt;
  // Responses with no outstanding read (e.g. straggling across a reset) are ignored.
  assign w_push        = IMem_RValid & r_inflight & ~Redirect;
  assign w_redirect_pc = Redirect_PC & 32'hFFFF_FFFC;
  assign Instr         = r_mem_instr[r_rd_ptr];
  assign Instr_PC      = r_mem_pc[r_rd_ptr];

  // Hold off the first request until the first clock edge after reset release.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Fetch PC advance and single outstanding-read tracking; redirect wins over a grant.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (Redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (Redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: each returned word is written together with the PC it was fetched from.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
      r_mem_instr[r_wr_ptr] <= IMem_RData;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, grant stalls, decode stalls, redirect, reset, PC wrap.
// A second instance with RESET_PC near the top of the address space runs free to exercise wrap-around.
// Memory model answers every grant one cycle later with data = address ^ 32'hA5A5_0000.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] XOR_K = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Gnt;
  logic        IMem_RValid;
  logic [31:0] IMem_RData;
  logic        Instr_Valid;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_Ready;

  logic        b_req;
  logic [31:0] b_addr;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        b_valid;
  logic [31:0] b_instr;
  logic [31:0] b_pc;

  logic        rv_q;
  logic [31:0] rd_q;
  logic        force_rv;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Gnt(IMem_Gnt),
    .IMem_RValid(IMem_RValid), .IMem_RData(IMem_RData),
    .Instr_Valid(Instr_Valid), .Instr(Instr), .Instr_PC(Instr_PC), .Instr_Ready(Instr_Ready)
  );

  instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .CLK(CLK), .Reset_n(Reset_n), .Redirect(1'b0), .Redirect_PC(32'h0),
    .IMem_Req(b_req), .IMem_Addr(b_addr), .IMem_Gnt(1'b1),
    .IMem_RValid(b_rvalid), .IMem_RData(b_rdata),
    .Instr_Valid(b_valid), .Instr(b_instr), .Instr_PC(b_pc), .Instr_Ready(1'b1)
  );

  // One-cycle read latency memory for both instances.
  always @(posedge CLK) begin
    rv_q     <= IMem_Req & IMem_Gnt;
    rd_q     <= IMem_Addr ^ XOR_K;
    b_rvalid <= b_req;
    b_rdata  <= b_addr ^ XOR_K;
  end
  assign IMem_RValid = rv_q | force_rv;
  assign IMem_RData  = rd_q;

  task automatic chk(input string tag, input logic ok, input logic [31:0] obs);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed %0h", tag, obs);
    end
  endtask

  // Leaves the caller at the negedge of cycle 0 (first cycle after the first post-release edge).
  task automatic do_reset();
    @(negedge CLK);
    Reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    Reset_n     = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = 32'h0;
    IMem_Gnt    = 1'b1;
    Instr_Ready = 1'b1;
    force_rv    = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_req",       IMem_Req    === 1'b0,          IMem_Req);
    chk("rst_addr",      IMem_Addr   === 32'h0,         IMem_Addr);
    chk("rst_valid",     Instr_Valid === 1'b0,          Instr_Valid);
    chk("rst_instr",     Instr       === 32'h0,         Instr);
    chk("rst_pc",        Instr_PC    === 32'h0,         Instr_PC);
    chk("rst_wrap_addr", b_addr      === 32'hFFFF_FFF8, b_addr);
    Reset_n = 1'b1;
    #1 chk("rel_req_before_edge", IMem_Req === 1'b0, IMem_Req);

    // Streaming: cycle 0 then cycle 1 requests, head valid from cycle 2
    @(negedge CLK);
    chk("c0_req",   IMem_Req    === 1'b1,  IMem_Req);
    chk("c0_addr",  IMem_Addr   === 32'h0, IMem_Addr);
    chk("c0_valid", Instr_Valid === 1'b0,  Instr_Valid);
    @(negedge CLK);
    chk("c1_addr",  IMem_Addr   === 32'h4, IMem_Addr);
    chk("c1_valid", Instr_Valid === 1'b0,  Instr_Valid);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      exp_pc = 32'(4 * i);
      chk("str_valid", Instr_Valid === 1'b1,           Instr_Valid);
      chk("str_pc",    Instr_PC    === exp_pc,         Instr_PC);
      chk("str_instr", Instr       === (exp_pc ^ XOR_K), Instr);
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
      chk("wrap_valid", b_valid === 1'b1,             b_valid);
      chk("wrap_pc",    b_pc    === exp_pc,           b_pc);
      chk("wrap_instr", b_instr === (exp_pc ^ XOR_K), b_instr);
    end

    // Grant withheld across three edges: address held, no advance, no push
    IMem_Gnt = 1'b0;
    @(negedge CLK);
    chk("ng1_req",  IMem_Req  === 1'b1,   IMem_Req);
    chk("ng1_addr", IMem_Addr === 32'h14, IMem_Addr);
    chk("ng1_pc",   Instr_PC  === 32'h10, Instr_PC);
    @(negedge CLK);
    chk("ng2_addr",  IMem_Addr   === 32'h14, IMem_Addr);
    chk("ng2_valid", Instr_Valid === 1'b0,   Instr_Valid);
    @(negedge CLK);
    chk("ng3_addr",  IMem_Addr   === 32'h14, IMem_Addr);
    chk("ng3_valid", Instr_Valid === 1'b0,   Instr_Valid);
    IMem_Gnt = 1'b1;
    @(negedge CLK);
    chk("ng_resume_valid", Instr_Valid === 1'b0,   Instr_Valid);
    chk("ng_resume_addr",  IMem_Addr   === 32'h18, IMem_Addr);
    @(negedge CLK);
    chk("ng_resume_pc",    Instr_PC === 32'h14,             Instr_PC);
    chk("ng_resume_instr", Instr    === (32'h14 ^ XOR_K),   Instr);
    @(negedge CLK);
    chk("ng_resume_pc2",   Instr_PC === 32'h18, Instr_PC);

    // Decode stall: buffer fills, request drops, nothing lost
    Instr_Ready = 1'b0;
    do_reset();
    @(negedge CLK);
    @(negedge CLK);
    chk("full_req_c2", IMem_Req === 1'b0,  IMem_Req);
    chk("full_pc_c2",  Instr_PC === 32'h0, Instr_PC);
    repeat (7) @(negedge CLK);
    chk("full_req_c9",  IMem_Req    === 1'b0,  IMem_Req);
    chk("full_addr_c9", IMem_Addr   === 32'h8, IMem_Addr);
    chk("full_valid",   Instr_Valid === 1'b1,  Instr_Valid);
    chk("full_pc_c9",   Instr_PC    === 32'h0, Instr_PC);
    Instr_Ready = 1'b1;
    #1 chk("full_req_on_pop", IMem_Req === 1'b1, IMem_Req);
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      exp_pc = 32'(4 * i);
      chk("drain_valid", Instr_Valid === 1'b1,             Instr_Valid);
      chk("drain_pc",    Instr_PC    === exp_pc,           Instr_PC);
      chk("drain_instr", Instr       === (exp_pc ^ XOR_K), Instr);
    end

    // Redirect with one entry buffered and one read in flight
    Instr_Ready = 1'b0;
    do_reset();
    @(negedge CLK);
    @(negedge CLK);
    chk("rd_pre_valid", Instr_Valid === 1'b1, Instr_Valid);
    chk("rd_pre_rv",    IMem_RValid === 1'b1, IMem_RValid);
    Redirect    = 1'b1;
    Redirect_PC = 32'h0000_1002;
    #1 chk("rd_req_blocked", IMem_Req === 1'b0, IMem_Req);
    @(negedge CLK);
    Redirect = 1'b0;
    #1;
    chk("rd_r1_valid", Instr_Valid === 1'b0,          Instr_Valid);
    chk("rd_r1_req",   IMem_Req    === 1'b1,          IMem_Req);
    chk("rd_r1_addr",  IMem_Addr   === 32'h0000_1000, IMem_Addr);
    Instr_Ready = 1'b1;
    @(negedge CLK);
    chk("rd_r2_valid", Instr_Valid === 1'b0, Instr_Valid);
    @(negedge CLK);
    chk("rd_r3_valid", Instr_Valid === 1'b1,          Instr_Valid);
    chk("rd_r3_pc",    Instr_PC    === 32'h0000_1000, Instr_PC);
    chk("rd_r3_instr", Instr       === 32'hA5A5_1000, Instr);
    @(negedge CLK);
    chk("rd_r4_pc",    Instr_PC === 32'h0000_1004, Instr_PC);

    // Reset mid-stream followed by a spurious read-valid
    Reset_n = 1'b0;
    #1;
    chk("mr_valid", Instr_Valid === 1'b0,  Instr_Valid);
    chk("mr_req",   IMem_Req    === 1'b0,  IMem_Req);
    chk("mr_addr",  IMem_Addr   === 32'h0, IMem_Addr);
    chk("mr_pc",    Instr_PC    === 32'h0, Instr_PC);
    @(negedge CLK);
    Reset_n  = 1'b1;
    force_rv = 1'b1;
    @(negedge CLK);
    chk("mr_c0_valid", Instr_Valid === 1'b0,  Instr_Valid);
    chk("mr_c0_addr",  IMem_Addr   === 32'h0, IMem_Addr);
    @(negedge CLK);
    force_rv = 1'b0;
    chk("mr_c1_valid", Instr_Valid === 1'b0, Instr_Valid);
    @(negedge CLK);
    chk("mr_c2_valid", Instr_Valid === 1'b1,  Instr_Valid);
    chk("mr_c2_pc",    Instr_PC    === 32'h0, Instr_PC);
    @(negedge CLK);
    chk("mr_c3_pc",    Instr_PC === 32'h4, Instr_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
